// File: rtl/ir_xmit.sv
// NEC infrared transmitter: serialises {address, command} or a repeat code into the mark/space envelope.
// Optional 38 kHz modulation of ir_led_o is enabled by defining IR_XMIT_CARRIER_EN.
module ir_xmit #(
    parameter int UNIT_CYC    = 15188,
    parameter int CARRIER_DIV = 711,
    parameter int CARRIER_HI  = 237,
    parameter int FRAME_UNITS = 192
) (
    input  logic        clk27,
    input  logic        reset,
    input  logic [15:0] code_i,
    input  logic        send_i,
    input  logic        repeat_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        ir_env_o,
    output logic        ir_rx_o,
    output logic        ir_led_o
);

    localparam int              PW        = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam logic [PW-1:0]   PRE_LAST  = PW'(UNIT_CYC - 1);
    localparam logic [7:0]      SLOT_LAST = 8'(FRAME_UNITS - 1);

    // The gap must absorb the longest frame (121 units) and the slot counter is 8 bits wide.
    if (UNIT_CYC < 1 || FRAME_UNITS < 122 || FRAME_UNITS > 255 ||
        CARRIER_HI < 1 || CARRIER_HI >= CARRIER_DIV) begin : g_bad_cfg
        $error("ir_xmit: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        STOP_MARK  = 3'd5,
        GAP        = 3'd6
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [PW-1:0]  pre_r;
    logic [4:0]     unit_cnt_r;
    logic [7:0]     slot_r;
    logic [5:0]     bit_r;
    logic [31:0]    shift_r;
    logic           rpt_r;
    logic           busy_r;
    logic           done_r;
    logic           env_r;
    logic           rx_r;
    logic           led_r;

    logic           unit_end_s;
    logic           last_unit_s;
    logic [4:0]     dur_s;
    logic           entry_s;
    logic           load_s;
    logic           done_s;
    logic           shift_s;
    logic           mark_s;

    assign unit_end_s  = (state_r != IDLE) && (pre_r == PRE_LAST);
    assign last_unit_s = unit_end_s && (unit_cnt_r == (dur_s - 5'd1));
    assign entry_s     = (state_s != state_r);
    assign shift_s     = (state_r == BIT_SPACE) && last_unit_s;
    assign mark_s      = (state_s == LEAD_MARK) || (state_s == BIT_MARK) || (state_s == STOP_MARK);

    // Length in units of the current timed state
    always_comb begin
        dur_s = 5'd1;
        case (state_r)
            LEAD_MARK:  dur_s = 5'd16;
            LEAD_SPACE: dur_s = rpt_r ? 5'd4 : 5'd8;
            BIT_MARK:   dur_s = 5'd1;
            BIT_SPACE:  dur_s = shift_r[0] ? 5'd3 : 5'd1;
            STOP_MARK:  dur_s = 5'd1;
            default:    dur_s = 5'd1;
        endcase
    end

    // Next-state logic; send_i wins over repeat_i, requests outside IDLE are dropped
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (send_i) begin
                    state_s = LEAD_MARK;
                    load_s  = 1'b1;
                end else if (repeat_i) begin
                    state_s = LEAD_MARK;
                end else begin
                    state_s = IDLE;
                end
            end
            LEAD_MARK: begin
                if (last_unit_s) state_s = LEAD_SPACE;
                else             state_s = LEAD_MARK;
            end
            LEAD_SPACE: begin
                if (last_unit_s) state_s = rpt_r ? STOP_MARK : BIT_MARK;
                else             state_s = LEAD_SPACE;
            end
            BIT_MARK: begin
                if (last_unit_s) state_s = BIT_SPACE;
                else             state_s = BIT_MARK;
            end
            BIT_SPACE: begin
                if (last_unit_s) state_s = (bit_r == 6'd31) ? STOP_MARK : BIT_MARK;
                else             state_s = BIT_SPACE;
            end
            STOP_MARK: begin
                if (last_unit_s) state_s = GAP;
                else             state_s = STOP_MARK;
            end
            GAP: begin
                if (unit_end_s && (slot_r == SLOT_LAST)) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = GAP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk27) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Unit prescaler, per-state unit count, slot count and bit shifter
    always_ff @(posedge clk27) begin
        if (reset) begin
            pre_r      <= PW'(0);
            unit_cnt_r <= 5'd0;
            slot_r     <= 8'd0;
            bit_r      <= 6'd0;
            shift_r    <= 32'd0;
            rpt_r      <= 1'b0;
        end else begin
            if (entry_s || unit_end_s || (state_r == IDLE)) pre_r <= PW'(0);
            else                                           pre_r <= pre_r + PW'(1);

            if (entry_s)         unit_cnt_r <= 5'd0;
            else if (unit_end_s) unit_cnt_r <= unit_cnt_r + 5'd1;
            else                 unit_cnt_r <= unit_cnt_r;

            if (state_s == IDLE) slot_r <= 8'd0;
            else if (unit_end_s) slot_r <= slot_r + 8'd1;
            else                 slot_r <= slot_r;

            if (state_r == IDLE) bit_r <= 6'd0;
            else if (shift_s)    bit_r <= bit_r + 6'd1;
            else                 bit_r <= bit_r;

            // LSB first on air: addr, ~addr, cmd, ~cmd
            if (load_s)       shift_r <= {~code_i[7:0], code_i[7:0], ~code_i[15:8], code_i[15:8]};
            else if (shift_s) shift_r <= {1'b0, shift_r[31:1]};
            else              shift_r <= shift_r;

            if (state_r == IDLE) rpt_r <= ~send_i;
            else                 rpt_r <= rpt_r;
        end
    end

`ifdef IR_XMIT_CARRIER_EN
    localparam int            CW    = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam logic [CW-1:0] CLAST = CW'(CARRIER_DIV - 1);
    localparam logic [CW-1:0] CHI   = CW'(CARRIER_HI);

    logic [CW-1:0] carr_r;
    logic [CW-1:0] carr_next_s;

    // Carrier phase restarts on every mark entry and idles at zero in spaces
    always_comb begin
        carr_next_s = CW'(0);
        if (mark_s && !entry_s) begin
            carr_next_s = (carr_r == CLAST) ? CW'(0) : (carr_r + CW'(1));
        end else begin
            carr_next_s = CW'(0);
        end
    end

    // Carrier counter and modulated LED drive
    always_ff @(posedge clk27) begin
        if (reset) begin
            carr_r <= CW'(0);
            led_r  <= 1'b0;
        end else begin
            carr_r <= carr_next_s;
            led_r  <= mark_s && (carr_next_s < CHI);
        end
    end
`else
    // Unmodulated LED drive mirrors the envelope
    always_ff @(posedge clk27) begin
        if (reset) led_r <= 1'b0;
        else       led_r <= mark_s;
    end
`endif

    // Registered status and envelope outputs
    always_ff @(posedge clk27) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            env_r  <= 1'b0;
            rx_r   <= 1'b1;
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= done_s;
            env_r  <= mark_s;
            rx_r   <= ~env_r;
        end
    end

    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign ir_env_o = env_r;
    assign ir_rx_o  = rx_r;
    assign ir_led_o = led_r;

endmodule

// File: tb/tb_ir_xmit.sv
// Directed bench for ir_xmit with shortened unit/carrier timing; hand-computed NEC run lengths.
module tb_ir_xmit;

    localparam int U    = 4;
    localparam int CDIV = 6;
    localparam int CHI  = 2;
    localparam int FU   = 192;
    localparam int MAXC = FU * U + 20;

    logic        clk27;
    logic        reset;
    logic [15:0] code_i;
    logic        send_i;
    logic        repeat_i;
    logic        busy_o;
    logic        done_o;
    logic        ir_env_o;
    logic        ir_rx_o;
    logic        ir_led_o;

    int checks;
    int failures;

    int   runs_q[$];
    int   slot_cyc;
    bit   done_seen;
    int   led_bad;
    int   rx_bad;
    int   busy_bad;
    logic first_busy;
    logic first_env;
    logic first_rx;

    ir_xmit #(
        .UNIT_CYC(U), .CARRIER_DIV(CDIV), .CARRIER_HI(CHI), .FRAME_UNITS(FU)
    ) dut (
        .clk27(clk27), .reset(reset), .code_i(code_i), .send_i(send_i),
        .repeat_i(repeat_i), .busy_o(busy_o), .done_o(done_o),
        .ir_env_o(ir_env_o), .ir_rx_o(ir_rx_o), .ir_led_o(ir_led_o)
    );

    initial begin
        clk27 = 1'b0;
        forever #5 clk27 = ~clk27;
    end

    // Issue a request and record envelope run lengths until done_o (or timeout).
    task automatic capture_slot(input logic s, input logic r, input logic [15:0] code,
                                input int inject_cyc);
        int   cur;
        int   mark_idx;
        logic prev;
        logic prev_rx_env;
        logic exp_led;
        code_i = code; send_i = s; repeat_i = r;
        @(posedge clk27); #1;
        send_i = 1'b0; repeat_i = 1'b0;
        first_busy = busy_o; first_env = ir_env_o; first_rx = ir_rx_o;
        runs_q.delete();
        cur = 1; prev = ir_env_o; prev_rx_env = 1'b0; mark_idx = 0;
        led_bad = 0; rx_bad = 0; busy_bad = 0; done_seen = 1'b0; slot_cyc = 0;
        for (int c = 0; c < MAXC; c++) begin
            if (c > 0) begin
                @(posedge clk27); #1;
            end
            if (c == inject_cyc) begin
                send_i = 1'b1; code_i = 16'hFFFF;
            end else begin
                send_i = 1'b0;
            end
            if (done_o) begin
                done_seen = 1'b1; slot_cyc = c;
                break;
            end
            if (c > 0) begin
                if (ir_env_o == prev) cur++;
                else begin
                    runs_q.push_back(cur); cur = 1; prev = ir_env_o;
                end
            end
            if (ir_rx_o !== ~prev_rx_env) rx_bad++;
            prev_rx_env = ir_env_o;
            if (busy_o !== 1'b1) busy_bad++;
`ifdef IR_XMIT_CARRIER_EN
            if (ir_env_o) begin
                exp_led = ((mark_idx % CDIV) < CHI);
                mark_idx++;
            end else begin
                exp_led = 1'b0;
                mark_idx = 0;
            end
`else
            exp_led = ir_env_o;
`endif
            if (ir_led_o !== exp_led) led_bad++;
        end
        send_i = 1'b0;
        if (done_seen) runs_q.push_back(cur);
    endtask

    function automatic logic [31:0] decode_runs();
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (runs_q.size() > 3 + 2 * i) w[i] = (runs_q[3 + 2 * i] == 3 * U);
        end
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b1; send_i = 1'b0; repeat_i = 1'b0; code_i = 16'h0000;
        repeat (3) @(posedge clk27);
        #1 reset = 1'b0;
        @(posedge clk27); #1;
        checks++; if (busy_o !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (done_o !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b exp=0", done_o); end
        checks++; if (ir_env_o !== 1'b0) begin failures++; $display("FAIL reset_env got=%b exp=0", ir_env_o); end
        checks++; if (ir_rx_o !== 1'b1)  begin failures++; $display("FAIL reset_rx got=%b exp=1", ir_rx_o); end
        checks++; if (ir_led_o !== 1'b0) begin failures++; $display("FAIL reset_led got=%b exp=0", ir_led_o); end
    endtask

    task automatic test_full_frame();
        int ones;
        int data_units;
        logic [31:0] w;
        capture_slot(1'b1, 1'b0, 16'h12AB, -1);
        checks++; if (first_busy !== 1'b1) begin failures++; $display("FAIL ff_start_busy got=%b exp=1", first_busy); end
        checks++; if (first_env !== 1'b1)  begin failures++; $display("FAIL ff_start_env got=%b exp=1", first_env); end
        checks++; if (first_rx !== 1'b1)   begin failures++; $display("FAIL ff_start_rx got=%b exp=1", first_rx); end
        checks++; if (!done_seen)          begin failures++; $display("FAIL ff_done_timeout got=0 exp=1"); end
        checks++; if (slot_cyc != FU * U)  begin failures++; $display("FAIL ff_slot_len got=%0d exp=%0d", slot_cyc, FU * U); end
        checks++; if (runs_q.size() != 68) begin failures++; $display("FAIL ff_run_count got=%0d exp=68", runs_q.size()); end
        if (runs_q.size() == 68) begin
            ones = 0; data_units = 0;
            for (int i = 2; i < 66; i++) data_units += runs_q[i];
            for (int i = 0; i < 32; i++) if (runs_q[3 + 2 * i] == 3 * U) ones++;
            w = decode_runs();
            checks++; if (runs_q[0] != 16 * U) begin failures++; $display("FAIL ff_lead_mark got=%0d exp=%0d", runs_q[0], 16 * U); end
            checks++; if (runs_q[1] != 8 * U)  begin failures++; $display("FAIL ff_lead_space got=%0d exp=%0d", runs_q[1], 8 * U); end
            checks++; if (w !== 32'h54AB_ED12)  begin failures++; $display("FAIL ff_decode got=%h exp=54abed12", w); end
            checks++; if (ones != 16)          begin failures++; $display("FAIL ff_ones got=%0d exp=16", ones); end
            checks++; if (data_units != 96 * U) begin failures++; $display("FAIL ff_data_units got=%0d exp=%0d", data_units, 96 * U); end
            checks++; if (runs_q[66] != U)     begin failures++; $display("FAIL ff_stop got=%0d exp=%0d", runs_q[66], U); end
            checks++; if (runs_q[67] != 71 * U) begin failures++; $display("FAIL ff_gap got=%0d exp=%0d", runs_q[67], 71 * U); end
        end
        checks++; if (rx_bad != 0)   begin failures++; $display("FAIL ff_rx_follow got=%0d exp=0", rx_bad); end
        checks++; if (led_bad != 0)  begin failures++; $display("FAIL ff_led got=%0d exp=0", led_bad); end
        checks++; if (busy_bad != 0) begin failures++; $display("FAIL ff_busy_span got=%0d exp=0", busy_bad); end
        @(posedge clk27); #1;
        checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL ff_done_pulse got=%b%b exp=00", done_o, busy_o);
        end
    endtask

    task automatic test_repeat();
        capture_slot(1'b0, 1'b1, 16'h0000, -1);
        checks++; if (!done_seen || slot_cyc != FU * U) begin
            failures++; $display("FAIL rpt_slot_len got=%0d exp=%0d", slot_cyc, FU * U);
        end
        checks++; if (runs_q.size() != 4) begin failures++; $display("FAIL rpt_run_count got=%0d exp=4", runs_q.size()); end
        if (runs_q.size() == 4) begin
            checks++; if (runs_q[0] != 16 * U || runs_q[1] != 4 * U || runs_q[2] != U || runs_q[3] != 171 * U) begin
                failures++;
                $display("FAIL rpt_runs got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d",
                         runs_q[0], runs_q[1], runs_q[2], runs_q[3], 16 * U, 4 * U, U, 171 * U);
            end
        end
        checks++; if (busy_bad != 0 || led_bad != 0 || rx_bad != 0) begin
            failures++; $display("FAIL rpt_side got=%0d/%0d/%0d exp=0/0/0", busy_bad, led_bad, rx_bad);
        end
    endtask

    task automatic test_priority();
        logic [31:0] w;
        capture_slot(1'b1, 1'b1, 16'hA55A, -1);
        w = decode_runs();
        checks++; if (runs_q.size() != 68) begin failures++; $display("FAIL prio_run_count got=%0d exp=68", runs_q.size()); end
        checks++; if (w !== 32'hA55A_5AA5) begin failures++; $display("FAIL prio_decode got=%h exp=a55a5aa5", w); end
    endtask

    task automatic test_ignore();
        logic [31:0] w;
        capture_slot(1'b1, 1'b0, 16'h12AB, 300);
        w = decode_runs();
        checks++; if (!done_seen || slot_cyc != FU * U) begin
            failures++; $display("FAIL ign_slot_len got=%0d exp=%0d", slot_cyc, FU * U);
        end
        checks++; if (w !== 32'h54AB_ED12) begin failures++; $display("FAIL ign_decode got=%h exp=54abed12", w); end
        checks++; if (busy_bad != 0) begin failures++; $display("FAIL ign_busy got=%0d exp=0", busy_bad); end
    endtask

    task automatic test_back_to_back();
        int c;
        bit hit;
        code_i = 16'h12AB; send_i = 1'b1;
        @(posedge clk27); #1;
        hit = 1'b0; c = 0;
        for (int k = 1; k < MAXC; k++) begin
            @(posedge clk27); #1;
            if (done_o) begin
                hit = 1'b1; c = k;
                break;
            end
        end
        checks++; if (!hit || c != FU * U) begin failures++; $display("FAIL b2b_slot_len got=%0d exp=%0d", c, FU * U); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy got=%b exp=0", busy_o); end
        @(posedge clk27); #1;
        checks++; if (busy_o !== 1'b1 || ir_env_o !== 1'b1) begin
            failures++; $display("FAIL b2b_restart got=%b%b exp=11", busy_o, ir_env_o);
        end
        send_i = 1'b0;
        reset = 1'b1;
        @(posedge clk27); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        int dones;
        int busys;
        code_i = 16'h12AB; send_i = 1'b1;
        @(posedge clk27); #1;
        send_i = 1'b0;
        // Bit 10 mark begins 50 units after leader start
        repeat (50 * U - 1) @(posedge clk27);
        #1;
        checks++; if (ir_env_o !== 1'b0) begin failures++; $display("FAIL rst_bit9_space got=%b exp=0", ir_env_o); end
        repeat (2) @(posedge clk27);
        #1;
        checks++; if (ir_env_o !== 1'b1) begin failures++; $display("FAIL rst_bit10_mark got=%b exp=1", ir_env_o); end
        reset = 1'b1;
        @(posedge clk27); #1;
        reset = 1'b0;
        checks++; if (busy_o !== 1'b0 || ir_env_o !== 1'b0 || done_o !== 1'b0) begin
            failures++; $display("FAIL rst_mid_outputs got=%b%b%b exp=000", busy_o, ir_env_o, done_o);
        end
        @(posedge clk27); #1;
        checks++; if (ir_rx_o !== 1'b1) begin failures++; $display("FAIL rst_mid_rx got=%b exp=1", ir_rx_o); end
        dones = 0; busys = 0;
        for (int k = 0; k < 40 * U; k++) begin
            @(posedge clk27); #1;
            if (done_o) dones++;
            if (busy_o || ir_env_o) busys++;
        end
        checks++; if (dones != 0 || busys != 0) begin
            failures++; $display("FAIL rst_mid_quiet got=%0d/%0d exp=0/0", dones, busys);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; send_i = 1'b0; repeat_i = 1'b0; code_i = 16'h0000;
        test_reset();
        test_full_frame();
        test_repeat();
        test_priority();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
